// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array feed scheduler.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_SIZE       = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_K_WIDTH    = 8;
    localparam int DEF_MAC_LAT    = 1;

    // Zero pushes needed so the last operand pair reaches the far corner PE and settles.
    function automatic int drain_cycles(input int size, input int mac_lat);
        return (size - 32'sd1) * 32'sd2 + mac_lat;
    endfunction

    localparam int DRAIN_CYC = drain_cycles(DEF_SIZE, DEF_MAC_LAT);

endpackage

// File: rtl/systolic_scheduler_skew.sv
// Per-lane skew delay line: DEPTH registers that advance only on shift,
// loading zero instead of din when zero is set.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic             zero,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];
    logic [WIDTH-1:0] head_s;

    // Select the value entering the first stage.
    always_comb begin
        head_s = zero ? {WIDTH{1'b0}} : din;
    end

    // Shift register with synchronous clear taking priority over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
        end else if (shift) begin
            stage_r[0] <= head_s;
            for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= stage_r[i];
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_scheduler.sv
// Tile scheduler for a SIZE x SIZE output-stationary systolic array:
// clears accumulators, feeds skewed operands with back-pressure, drains, pulses done.
module systolic_scheduler
    import systolic_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K_WIDTH    = DEF_K_WIDTH,
    parameter int MAC_LAT    = DEF_MAC_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [SIZE*DATA_WIDTH-1:0] act_data,
    input  logic                       wt_valid,
    output logic                       wt_ready,
    input  logic [SIZE*DATA_WIDTH-1:0] wt_data,
    output logic                       arr_enable,
    output logic                       arr_acc_clear,
    output logic [SIZE*DATA_WIDTH-1:0] arr_a,
    output logic [SIZE*DATA_WIDTH-1:0] arr_w,
    output logic                       busy,
    output logic                       done
);

    localparam int DRAIN_LEN = drain_cycles(SIZE, MAC_LAT);
    localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);

    state_e              state_r, state_s;
    logic [K_WIDTH-1:0]  k_len_r, k_cnt_r;
    logic [DCNT_W-1:0]   drain_cnt_r;
    logic                arr_enable_r, arr_acc_clear_r, busy_r, done_r;
    logic                fire_s, shift_s, clr_s, zero_s, last_fire_s, drain_last_s;

    assign fire_s       = (state_r == ST_FEED) & act_valid & wt_valid;
    assign clr_s        = (state_r == ST_CLEAR);
    assign shift_s      = fire_s | (state_r == ST_DRAIN);
    assign zero_s       = (state_r != ST_FEED);
    assign last_fire_s  = (k_cnt_r == (k_len_r - K_WIDTH'(1)));
    assign drain_last_s = (drain_cnt_r == DCNT_W'(DRAIN_LEN - 1));

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_s = ST_CLEAR; else state_s = ST_IDLE;
            ST_CLEAR: if (k_len_r == {K_WIDTH{1'b0}}) state_s = ST_DRAIN; else state_s = ST_FEED;
            ST_FEED:  if (fire_s && last_fire_s) state_s = ST_DRAIN; else state_s = ST_FEED;
            ST_DRAIN: if (drain_last_s) state_s = ST_DONE; else state_s = ST_DRAIN;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, tile counters and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            k_len_r         <= {K_WIDTH{1'b0}};
            k_cnt_r         <= {K_WIDTH{1'b0}};
            drain_cnt_r     <= {DCNT_W{1'b0}};
            arr_enable_r    <= 1'b0;
            arr_acc_clear_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE && start) k_len_r <= k_len;
            else k_len_r <= k_len_r;
            if (clr_s) k_cnt_r <= {K_WIDTH{1'b0}};
            else if (fire_s) k_cnt_r <= k_cnt_r + K_WIDTH'(1);
            else k_cnt_r <= k_cnt_r;
            if (state_r == ST_DRAIN) drain_cnt_r <= drain_cnt_r + DCNT_W'(1);
            else drain_cnt_r <= {DCNT_W{1'b0}};
            // The array steps exactly when the skew lines moved, so stalls freeze it.
            arr_enable_r    <= clr_s | shift_s;
            arr_acc_clear_r <= clr_s;
            busy_r          <= (state_s != ST_IDLE);
            done_r          <= (state_s == ST_DONE);
        end
    end

    assign act_ready     = fire_s;
    assign wt_ready      = fire_s;
    assign arr_enable    = arr_enable_r;
    assign arr_acc_clear = arr_acc_clear_r;
    assign busy          = busy_r;
    assign done          = done_r;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_act_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_s),
            .shift (shift_s),
            .zero  (zero_s),
            .din   (act_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (arr_a[i*DATA_WIDTH +: DATA_WIDTH])
        );
        skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_wt_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_s),
            .shift (shift_s),
            .zero  (zero_s),
            .din   (wt_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (arr_w[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Scoreboard bench: a behavioural 4x4 PE array consumes the scheduler outputs;
// expected accumulators, done latency and enable counts are queued per tile.
module tb_systolic_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  k_len = 8'd0;
    logic        act_valid = 1'b0, wt_valid = 1'b0;
    logic        act_ready, wt_ready;
    logic [31:0] act_data = 32'd0, wt_data = 32'd0;
    logic        arr_enable, arr_acc_clear, busy, done;
    logic [31:0] arr_a, arr_w;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int en_base = 0;
    int en_cnt = 0;
    int rdy_cnt = 0;
    int lat_q[$];
    int en_q[$];
    int acc_q[$];

    logic signed [7:0] a_p [4][4];
    logic signed [7:0] w_p [4][4];
    int                acc_m [4][4];

    systolic_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .arr_enable(arr_enable), .arr_acc_clear(arr_acc_clear),
        .arr_a(arr_a), .arr_w(arr_w), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary PE array: a flows right, w flows down.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || arr_acc_clear) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    acc_m[r][c] <= 0; a_p[r][c] <= 8'sd0; w_p[r][c] <= 8'sd0;
                end
        end else if (arr_enable) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    logic signed [7:0] ai, wi;
                    ai = (c == 0) ? arr_a[r*8 +: 8] : a_p[r][c-1];
                    wi = (r == 0) ? arr_w[c*8 +: 8] : w_p[r-1][c];
                    acc_m[r][c] <= acc_m[r][c] + int'(ai) * int'(wi);
                    a_p[r][c] <= ai;
                    w_p[r][c] <= wi;
                end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the next queued tile expectation.
    always @(negedge clk) begin
        if (arr_enable) en_cnt++;
        if (act_ready) rdy_cnt++;
        if (done) begin
            if (lat_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                check("done_latency", cyc - start_cyc, lat_q.pop_front());
                check("enable_cycles", en_cnt - en_base, en_q.pop_front());
                @(posedge clk); #1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        check($sformatf("acc_%0d_%0d", r, c), acc_m[r][c], acc_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] act_vec(input int mode, input int k);
        logic [31:0] v;
        v = 32'd0;
        for (int r = 0; r < 4; r++)
            v[r*8 +: 8] = (mode == 1) ? 8'h80 : ((r == k) ? 8'd1 : 8'd0);
        return v;
    endfunction

    function automatic logic [31:0] wt_vec(input int mode, input int k);
        logic [31:0] v;
        v = 32'd0;
        for (int c = 0; c < 4; c++)
            v[c*8 +: 8] = (mode == 1) ? 8'h80 : 8'(4 * k + c + 1);
        return v;
    endfunction

    // Runs one tile; stall cycles are 1-based FEED cycle numbers with act_valid low (0 = none).
    task automatic run_tile(input int kl, input int st_a, input int st_b, input bit poke, input int mode);
        int fires, fc, guard, stalls;
        stalls = (st_a != 0 ? 1 : 0) + (st_b != 0 ? 1 : 0);
        lat_q.push_back(kl + 9 + stalls);
        en_q.push_back(kl + 8);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kl == 0) acc_q.push_back(0);
                else if (mode == 1) acc_q.push_back(4177920);
                else acc_q.push_back(4 * r + c + 1);
        @(negedge clk);
        start = 1'b1; k_len = 8'(kl); start_cyc = cyc; en_base = en_cnt;
        @(negedge clk);
        start = 1'b0;
        fires = 0; fc = 0;
        while (fires < kl && fc < 2000) begin
            @(negedge clk);
            fc++;
            act_valid = !(fc == st_a || fc == st_b);
            wt_valid  = 1'b1;
            act_data  = act_vec(mode, fires);
            wt_data   = wt_vec(mode, fires);
            start     = poke && fc == 2;
            k_len     = (poke && fc == 2) ? 8'd1 : 8'(kl);
            #1;
            if (fc <= 3 || act_ready) check("feed_ready", wt_ready, act_valid);
            if (act_ready) fires++;
        end
        if (fc >= 2000) begin
            checks++; failures++;
            $display("FAIL feed_timeout actual=%0d expected=%0d", fires, kl);
        end
        @(negedge clk);
        act_valid = (kl == 0); wt_valid = (kl == 0);
        start = poke; k_len = poke ? 8'd1 : 8'(kl);
        @(negedge clk);
        start = 1'b0; k_len = 8'(kl);
        guard = 0;
        while ((lat_q.size() != 0 || acc_q.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        act_valid = 1'b0; wt_valid = 1'b0;
        if (guard >= 2000) begin
            checks++; failures++;
            $display("FAIL tile_timeout actual=%0d expected=%0d", lat_q.size(), 0);
            lat_q.delete(); en_q.delete(); acc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int rdy_base, fires;
        act_valid = 1'b1; wt_valid = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enable", arr_enable, 0);
        check("rst_acc_clear", arr_acc_clear, 0);
        check("rst_arr_a", arr_a, 0);
        check("rst_arr_w", arr_w, 0);
        check("rst_act_ready", act_ready, 0);
        check("rst_wt_ready", wt_ready, 0);
        @(negedge clk);
        act_valid = 1'b0; wt_valid = 1'b0; start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_tile(4, 0, 0, 1'b0, 0);     // identity, no stalls
        run_tile(4, 2, 3, 1'b0, 0);     // act_valid low on FEED cycles 2 and 3
        run_tile(255, 0, 0, 1'b0, 1);   // -128 x -128 over 255 steps
        rdy_base = rdy_cnt;
        run_tile(0, 0, 0, 1'b0, 0);     // empty reduction
        check("k0_ready_never", rdy_cnt - rdy_base, 0);
        run_tile(4, 0, 0, 1'b1, 0);     // start pokes in FEED and DRAIN ignored

        // Abandon a tile after two accepted columns.
        @(negedge clk);
        start = 1'b1; k_len = 8'd4;
        @(negedge clk);
        start = 1'b0; fires = 0;
        for (int fc = 0; fc < 20 && fires < 2; fc++) begin
            @(negedge clk);
            act_valid = 1'b1; wt_valid = 1'b1;
            act_data = act_vec(0, fires); wt_data = wt_vec(0, fires);
            #1;
            if (act_ready) fires++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_enable", arr_enable, 0);
        check("midrst_arr_a", arr_a, 0);
        check("midrst_arr_w", arr_w, 0);
        check("midrst_act_ready", act_ready, 0);
        @(negedge clk);
        act_valid = 1'b0; wt_valid = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_idle", busy, 0);
        run_tile(4, 0, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
